// File: rtl/avalon_bus_master_if.sv
// avalon_bus_master_if: command-side and Avalon-MM request/response signals of avalon_bus_master.
interface avalon_bus_master_if;
  logic i_Cmd_Valid;
  logic o_Cmd_Ready;
  logic i_Cmd_Write;
  logic [31:0] i_Cmd_Addr;
  logic [3:0] i_Cmd_ByteEn;
  logic [31:0] i_Cmd_WriteData;
  logic o_Rsp_Valid;
  logic [31:0] o_Rsp_ReadData;
  logic o_Rsp_Error;
  logic [31:0] o_AV_Address;
  logic [3:0] o_AV_ByteEn;
  logic [31:0] o_AV_WriteData;
  logic o_AV_Read;
  logic o_AV_Write;
  logic [31:0] i_AV_ReadData;
  logic i_AV_WaitRequest;
  modport master (
    input i_Cmd_Valid, i_Cmd_Write, i_Cmd_Addr, i_Cmd_ByteEn, i_Cmd_WriteData, i_AV_ReadData, i_AV_WaitRequest,
    output o_Cmd_Ready, o_Rsp_Valid, o_Rsp_ReadData, o_Rsp_Error, o_AV_Address, o_AV_ByteEn, o_AV_WriteData,
    o_AV_Read, o_AV_Write
  );
  modport slave (
    output i_Cmd_Valid, i_Cmd_Write, i_Cmd_Addr, i_Cmd_ByteEn, i_Cmd_WriteData, i_AV_ReadData, i_AV_WaitRequest,
    input o_Cmd_Ready, o_Rsp_Valid, o_Rsp_ReadData, o_Rsp_Error, o_AV_Address, o_AV_ByteEn, o_AV_WriteData,
    o_AV_Read, o_AV_Write
  );
endinterface

// File: rtl/avalon_bus_master.sv
// avalon_bus_master: single-outstanding command to Avalon-MM master with fixed read latency.
// Define AV_MASTER_TIMEOUT_EN to abort requests stalled by waitrequest for TIMEOUT_CYCLES cycles.
module avalon_bus_master #(
  parameter int READ_LATENCY = 1,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic i_Clk,
  input logic i_Reset,
  avalon_bus_master_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_DATA, RESP} state_t;
  state_t state;
  logic [1:0] latCnt;
  if (READ_LATENCY < 0 || READ_LATENCY > 3 || TIMEOUT_CYCLES < 1) begin : g_badParams
    $error("avalon_bus_master: READ_LATENCY must be 0..3 and TIMEOUT_CYCLES at least 1");
  end
`ifdef AV_MASTER_TIMEOUT_EN
  localparam int CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] stallCnt;
`else
  assign bus.o_Rsp_Error = 1'b0;
`endif
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state <= IDLE;
      latCnt <= '0;
      bus.o_Cmd_Ready <= 1'b1;
      bus.o_Rsp_Valid <= 1'b0;
      bus.o_Rsp_ReadData <= '0;
      bus.o_AV_Address <= '0;
      bus.o_AV_ByteEn <= '0;
      bus.o_AV_WriteData <= '0;
      bus.o_AV_Read <= 1'b0;
      bus.o_AV_Write <= 1'b0;
`ifdef AV_MASTER_TIMEOUT_EN
      stallCnt <= '0;
      bus.o_Rsp_Error <= 1'b0;
`endif
    end else begin
      bus.o_Rsp_Valid <= 1'b0;
      case (state)
        IDLE: if (bus.i_Cmd_Valid) begin
          state <= REQ;
          latCnt <= 2'd1;
          bus.o_Cmd_Ready <= 1'b0;
          bus.o_AV_Read <= !bus.i_Cmd_Write;
          bus.o_AV_Write <= bus.i_Cmd_Write;
          bus.o_AV_Address <= bus.i_Cmd_Addr;
          bus.o_AV_ByteEn <= bus.i_Cmd_ByteEn;
          bus.o_AV_WriteData <= bus.i_Cmd_WriteData;
`ifdef AV_MASTER_TIMEOUT_EN
          stallCnt <= '0;
`endif
        end
        REQ: if (!bus.i_AV_WaitRequest) begin
          bus.o_AV_Read <= 1'b0;
          bus.o_AV_Write <= 1'b0;
          // Zero-latency reads sample the data on the same edge the request is accepted
          if (bus.o_AV_Write || READ_LATENCY == 0) begin
            state <= RESP;
            bus.o_Rsp_Valid <= 1'b1;
            bus.o_Rsp_ReadData <= bus.o_AV_Write ? '0 : bus.i_AV_ReadData;
          end else
            state <= WAIT_DATA;
        end
`ifdef AV_MASTER_TIMEOUT_EN
        else if (stallCnt == CntW'(TIMEOUT_CYCLES - 1)) begin
          state <= RESP;
          bus.o_AV_Read <= 1'b0;
          bus.o_AV_Write <= 1'b0;
          bus.o_Rsp_Valid <= 1'b1;
          bus.o_Rsp_ReadData <= '0;
          bus.o_Rsp_Error <= 1'b1;
        end else
          stallCnt <= stallCnt + 1'b1;
`endif
        WAIT_DATA: if (latCnt == 2'(READ_LATENCY)) begin
          state <= RESP;
          bus.o_Rsp_Valid <= 1'b1;
          bus.o_Rsp_ReadData <= bus.i_AV_ReadData;
        end else
          latCnt <= latCnt + 2'd1;
        RESP: begin
          state <= IDLE;
          bus.o_Cmd_Ready <= 1'b1;
          bus.o_Rsp_ReadData <= '0;
`ifdef AV_MASTER_TIMEOUT_EN
          bus.o_Rsp_Error <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_avalon_bus_master.sv
// tb_avalon_bus_master: randomized transactions against a memory-backed slave model with
// cycle-count expectations derived from wait states, read latency and the optional timeout.
module tb_avalon_bus_master;
  localparam int LAT = 1;
  localparam int TO = 8;
  logic i_Clk = 1'b0;
  logic i_Reset = 1'b1;
  int errors = 0;
  int checks = 0;
  logic [31:0] mem [logic [31:0]];
  avalon_bus_master_if bus ();
  avalon_bus_master #(.READ_LATENCY(LAT), .TIMEOUT_CYCLES(TO)) dut (.i_Clk(i_Clk), .i_Reset(i_Reset), .bus(bus));
  always #5 i_Clk = ~i_Clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  function automatic logic [31:0] memRd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] be, input logic [31:0] wd);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction
  task automatic run_txn(input string nm, input bit wr, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wd, input int waits);
    bit timedOut, errGot, shapeOk;
    int strobeExp, respExp, dataCyc, strobes, pulses, respAt;
    logic [31:0] rdExp, rdGot;
    timedOut = 1'b0;
`ifdef AV_MASTER_TIMEOUT_EN
    timedOut = waits >= TO;
`endif
    strobeExp = timedOut ? TO : waits + 1;
    respExp = timedOut ? TO + 1 : waits + 2 + (wr ? 0 : LAT);
    dataCyc = waits + 1 + LAT;
    rdExp = (wr || timedOut) ? 32'h0 : memRd(addr);
    @(negedge i_Clk);
    checks++;
    if (bus.o_Cmd_Ready !== 1'b1) begin
      errors++;
      $display("FAIL %s idle_ready: got %b want 1", nm, bus.o_Cmd_Ready);
    end
    bus.i_Cmd_Valid = 1'b1;
    bus.i_Cmd_Write = wr;
    bus.i_Cmd_Addr = addr;
    bus.i_Cmd_ByteEn = be;
    bus.i_Cmd_WriteData = wd;
    bus.i_AV_ReadData = $urandom;
    @(posedge i_Clk);
    strobes = 0; pulses = 0; respAt = 0; shapeOk = 1'b1; rdGot = 32'h0; errGot = 1'b0;
    for (int c = 1; c <= respExp + 1; c++) begin
      @(negedge i_Clk);
      bus.i_Cmd_Valid = 1'b0;
      bus.i_Cmd_Addr = $urandom;
      bus.i_Cmd_WriteData = $urandom;
      bus.i_AV_WaitRequest = (c <= waits);
      bus.i_AV_ReadData = (!wr && c == dataCyc) ? memRd(addr) : $urandom;
      if (bus.o_AV_Read || bus.o_AV_Write) begin
        strobes++;
        if (c > strobeExp || bus.o_AV_Write !== wr || bus.o_AV_Read !== !wr || bus.o_AV_Address !== addr ||
            bus.o_AV_ByteEn !== be || (wr && bus.o_AV_WriteData !== wd)) shapeOk = 1'b0;
      end
      if (bus.o_Rsp_Valid) begin
        pulses++;
        respAt = c;
        rdGot = bus.o_Rsp_ReadData;
        errGot = bus.o_Rsp_Error;
      end
      if (bus.o_Cmd_Ready !== (c > respExp)) shapeOk = 1'b0;
    end
    if (wr && !timedOut) mem[addr] = merge(memRd(addr), be, wd);
    checks++;
    if (strobes != strobeExp) begin errors++; $display("FAIL %s strobe_cycles: got %0d want %0d", nm, strobes, strobeExp); end
    checks++;
    if (!shapeOk) begin errors++; $display("FAIL %s fields_or_ready: got bad want stable fields and ready only after response", nm); end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL %s rsp_pulses: got %0d want 1", nm, pulses); end
    checks++;
    if (respAt != respExp) begin errors++; $display("FAIL %s rsp_cycle: got %0d want %0d", nm, respAt, respExp); end
    checks++;
    if (rdGot !== rdExp) begin errors++; $display("FAIL %s rsp_data: got %h want %h", nm, rdGot, rdExp); end
    checks++;
    if (errGot !== timedOut) begin errors++; $display("FAIL %s rsp_error: got %b want %b", nm, errGot, timedOut); end
  endtask
  task automatic test_reset();
    i_Reset = 1'b1;
    bus.i_Cmd_Valid = 1'b1;
    bus.i_Cmd_Write = 1'b1;
    bus.i_Cmd_Addr = $urandom;
    bus.i_Cmd_ByteEn = 4'hF;
    bus.i_Cmd_WriteData = $urandom;
    bus.i_AV_ReadData = $urandom;
    bus.i_AV_WaitRequest = 1'b0;
    repeat (2) @(posedge i_Clk);
    @(negedge i_Clk);
    checks++;
    if ({bus.o_Cmd_Ready, bus.o_AV_Read, bus.o_AV_Write, bus.o_Rsp_Valid, bus.o_Rsp_Error} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 10000", {bus.o_Cmd_Ready, bus.o_AV_Read, bus.o_AV_Write, bus.o_Rsp_Valid, bus.o_Rsp_Error});
    end
    checks++;
    if ({bus.o_Rsp_ReadData, bus.o_AV_Address, bus.o_AV_ByteEn, bus.o_AV_WriteData} !== 100'h0) begin
      errors++;
      $display("FAIL reset_data: got %h want 0", {bus.o_Rsp_ReadData, bus.o_AV_Address, bus.o_AV_ByteEn, bus.o_AV_WriteData});
    end
    bus.i_Cmd_Valid = 1'b0;
    i_Reset = 1'b0;
  endtask
  task automatic test_write();
    run_txn("write_deadbeef", 1'b1, 32'h3, 4'hF, 32'hDEADBEEF, 0);
  endtask
  task automatic test_read();
    mem[32'h3] = 32'h01A5A5A5;
    run_txn("read_latency", 1'b0, 32'h3, 4'hF, 32'h0, 0);
  endtask
  task automatic test_waitrequest();
    run_txn("read_wait5", 1'b0, 32'h3, 4'hF, 32'h0, 5);
    run_txn("write_wait3", 1'b1, 32'h5, 4'h6, 32'h12345678, 3);
  endtask
  task automatic test_timeout();
    run_txn("read_stall12", 1'b0, 32'h5, 4'hF, 32'h0, 12);
    run_txn("write_stall8", 1'b1, 32'h6, 4'hF, 32'hCAFEF00D, 8);
    run_txn("read_after_stall", 1'b0, 32'h6, 4'hF, 32'h0, 1);
  endtask
  task automatic test_random();
    for (int i = 0; i < 30; i++)
      run_txn("random", 1'($urandom_range(0, 1)), 32'($urandom_range(0, 7)), 4'($urandom_range(1, 15)), $urandom,
              $urandom_range(0, 4));
  endtask
  task automatic test_reset_mid();
    int rspSeen, strobeSeen;
    @(negedge i_Clk);
    bus.i_Cmd_Valid = 1'b1;
    bus.i_Cmd_Write = 1'b0;
    bus.i_Cmd_Addr = 32'h2;
    bus.i_AV_WaitRequest = 1'b1;
    @(posedge i_Clk);
    @(negedge i_Clk);
    bus.i_Cmd_Valid = 1'b0;
    repeat (2) @(negedge i_Clk);
    checks++;
    if (bus.o_AV_Read !== 1'b1) begin errors++; $display("FAIL reset_mid_stall_strobe: got %b want 1", bus.o_AV_Read); end
    i_Reset = 1'b1;
    @(negedge i_Clk);
    i_Reset = 1'b0;
    bus.i_AV_WaitRequest = 1'b0;
    checks++;
    if ({bus.o_AV_Read, bus.o_AV_Write, bus.o_Rsp_Valid, bus.o_Cmd_Ready} !== 4'b0001) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %b want 0001", {bus.o_AV_Read, bus.o_AV_Write, bus.o_Rsp_Valid, bus.o_Cmd_Ready});
    end
    rspSeen = 0; strobeSeen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge i_Clk);
      rspSeen += int'(bus.o_Rsp_Valid);
      strobeSeen += int'(bus.o_AV_Read || bus.o_AV_Write);
    end
    checks++;
    if (rspSeen != 0 || strobeSeen != 0) begin
      errors++;
      $display("FAIL reset_mid_abandon: got rsp=%0d strobes=%0d want 0 0", rspSeen, strobeSeen);
    end
    run_txn("after_reset", 1'b0, 32'h3, 4'hF, 32'h0, 2);
  endtask
  task automatic test_back_to_back();
    int respA, accB, respB, pulses, wrStrobes, rdStrobes;
    logic [31:0] newVal;
    logic [31:0] got [2];
    int at [2];
    bit readyOk;
    respA = 2;
    accB = respA + 1;
    respB = accB + 2 + LAT;
    newVal = merge(memRd(32'h4), 4'h3, 32'h00C0FFEE);
    @(negedge i_Clk);
    bus.i_Cmd_Valid = 1'b1;
    bus.i_Cmd_Write = 1'b1;
    bus.i_Cmd_Addr = 32'h4;
    bus.i_Cmd_ByteEn = 4'h3;
    bus.i_Cmd_WriteData = 32'h00C0FFEE;
    bus.i_AV_WaitRequest = 1'b0;
    bus.i_AV_ReadData = newVal;
    @(posedge i_Clk);
    pulses = 0; wrStrobes = 0; rdStrobes = 0; readyOk = 1'b1;
    at[0] = 0; at[1] = 0; got[0] = 32'hX; got[1] = 32'hX;
    for (int c = 1; c <= respB + 1; c++) begin
      @(negedge i_Clk);
      bus.i_Cmd_Write = 1'b0;
      bus.i_Cmd_WriteData = $urandom;
      if (c > accB) bus.i_Cmd_Valid = 1'b0;
      wrStrobes += int'(bus.o_AV_Write);
      rdStrobes += int'(bus.o_AV_Read);
      if (bus.o_Rsp_Valid) begin
        if (pulses < 2) begin got[pulses] = bus.o_Rsp_ReadData; at[pulses] = c; end
        pulses++;
      end
      if (bus.o_Cmd_Ready !== (c == accB || c > respB)) readyOk = 1'b0;
    end
    mem[32'h4] = newVal;
    checks++;
    if (pulses != 2) begin errors++; $display("FAIL b2b_pulses: got %0d want 2", pulses); end
    checks++;
    if (at[0] != respA || got[0] !== 32'h0) begin
      errors++; $display("FAIL b2b_first: got cycle %0d data %h want cycle %0d data 0", at[0], got[0], respA);
    end
    checks++;
    if (at[1] != respB || got[1] !== newVal) begin
      errors++; $display("FAIL b2b_second: got cycle %0d data %h want cycle %0d data %h", at[1], got[1], respB, newVal);
    end
    checks++;
    if (wrStrobes != 1 || rdStrobes != 1 || !readyOk) begin
      errors++; $display("FAIL b2b_strobes_ready: got wr=%0d rd=%0d ready_ok=%b want 1 1 1", wrStrobes, rdStrobes, readyOk);
    end
  endtask
  initial begin
    test_reset();
    test_write();
    test_read();
    test_waitrequest();
    test_timeout();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/avalon_bus_master.md
AVALON_BUS_MASTER -- requirements
Module: avalon_bus_master

Interface
REQ-001 SHALL have parameter READ_LATENCY, 1, fixed cycles from read acceptance to data sampling; legal values 0 to 3.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, 256, waitrequest-stall limit; used only with AV_MASTER_TIMEOUT_EN.
REQ-003 i_Clk  in  1  sole clock; all logic on its rising edge.
REQ-004 i_Reset  in  1  synchronous, active-high reset.
REQ-005 i_Cmd_Valid  in  1  command present.
REQ-006 o_Cmd_Ready  out  1  command accepted when high together with i_Cmd_Valid.
REQ-007 i_Cmd_Write  in  1  1 = write, 0 = read.
REQ-008 i_Cmd_Addr  in  32  target word address.
REQ-009 i_Cmd_ByteEn  in  4  byte lanes.
REQ-010 i_Cmd_WriteData  in  32  write data.
REQ-011 o_Rsp_Valid  out  1  one-cycle response pulse.
REQ-012 o_Rsp_ReadData  out  32  read result; 0 for writes and errors.
REQ-013 o_Rsp_Error  out  1  transaction timed out; valid with o_Rsp_Valid.
REQ-014 o_AV_Address, o_AV_ByteEn, o_AV_WriteData  out  32/4/32  Avalon master request fields.
REQ-015 o_AV_Read, o_AV_Write  out  1 each  Avalon strobes.
REQ-016 i_AV_ReadData  in  32  Avalon read data; i_AV_WaitRequest  in  1  slave stall.

Function
REQ-017 SHALL implement states IDLE, REQ, WAIT_DATA, RESP.
REQ-018 IDLE: o_Cmd_Ready = 1; on i_Cmd_Valid at an edge, register all command fields and enter REQ.
REQ-019 o_Cmd_Ready SHALL be 0 in all states other than IDLE; only one transaction outstanding.
REQ-020 REQ: o_AV_Read = !write, o_AV_Write = write, fields driven from registered command; strobes first assert the cycle after acceptance.
REQ-021 Request accepted at the first edge in REQ where i_AV_WaitRequest = 0; strobes, address, data and byte-enables held stable until then.
REQ-022 Write accepted: go to RESP with o_Rsp_ReadData = 0, o_Rsp_Error = 0.
REQ-023 Read accepted at edge N: if READ_LATENCY = 0, capture i_AV_ReadData at edge N and go to RESP; else go to WAIT_DATA and capture at edge N+READ_LATENCY, then go to RESP.
REQ-024 Strobes SHALL be 0 in IDLE, WAIT_DATA and RESP; an accepted request never repeats.
REQ-025 RESP: o_Rsp_Valid = 1 for exactly one cycle, then IDLE; no response back-pressure.
REQ-026 Minimum command-to-command spacing: 3 cycles (accept, REQ, RESP) with zero wait states and READ_LATENCY = 0.
REQ-027 i_Cmd_Valid while busy SHALL be ignored; no command is lost because ready stays low.

Reset
REQ-028 While i_Reset is high at an edge: state to IDLE; all outputs, strobes, registered fields and counters to 0, except o_Cmd_Ready, which goes to 1 at that edge.
REQ-029 Reset mid-transaction SHALL abandon it: strobes 0 at that edge, no o_Rsp_Valid pulse issued.

Configuration
REQ-030 With macro AV_MASTER_TIMEOUT_EN defined: count consecutive REQ cycles with i_AV_WaitRequest = 1.
REQ-031 When the count reaches TIMEOUT_CYCLES, drop the strobes and enter RESP with o_Rsp_Error = 1 and o_Rsp_ReadData = 0.
REQ-032 With AV_MASTER_TIMEOUT_EN defined, the counter SHALL clear on entry to REQ.
REQ-033 Without AV_MASTER_TIMEOUT_EN: no counter, REQ waits indefinitely, o_Rsp_Error tied to 0.

Verification
REQ-034 Write 0xDEADBEEF, addr 0x3, ByteEn 0xF, waitrequest 0 -> o_AV_Write high one cycle with those fields; Rsp_Valid one cycle later, ReadData 0, Error 0.
REQ-035 Read addr 0x3, READ_LATENCY = 1, slave returns 0x01A5A5A5 one cycle after accept -> Rsp_ReadData = 0x01A5A5A5, strobe high exactly one cycle.
REQ-036 Read with waitrequest held high for 5 cycles -> o_AV_Read high 6 cycles with address stable; single Rsp_Valid pulse.
REQ-037 Timeout enabled, TIMEOUT_CYCLES = 8, waitrequest stuck high -> strobe drops after 8 stall cycles; Rsp_Valid with Error = 1, ReadData 0.
REQ-038 i_Reset asserted during the waitrequest stall -> strobes 0 at that edge, no Rsp_Valid, Cmd_Ready = 1; next command completes normally.
REQ-039 Back-to-back Valid held high for 2 commands -> second accepted only after the first Rsp_Valid; responses in order.
